// File: rtl/frame_loader.sv
// Double-buffered 16x16 one-bit frame store. Serial data is loaded into the back bank,
// and the banks swap only on a panel frame_sync, so the driver never shows a torn frame.
module frame_loader #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs_in,
    input  logic             sclk_in,
    input  logic             sdata_in,
    input  logic             frame_sync_in,
    input  logic [3:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             frame_pending_out,
    output logic             overrun_out,
    output logic             bank_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sdata_sync;
    logic                   cs_prev;
    logic                   sclk_prev;
    logic [WIDTH-2:0]       shift;
    logic [3:0]             bit_cnt;
    logic [3:0]             word_ptr;
    logic                   bank_sel;
    logic [WIDTH-1:0]       mem [2][DEPTH];

    logic                   cs_s;
    logic                   sclk_s;
    logic                   sdata_s;
    logic                   cs_rise_s;
    logic                   sclk_rise_s;
    logic                   wr_en_s;
    logic [WIDTH-1:0]       wr_word_s;

    assign cs_s        = cs_sync[SYNC_STAGES-1];
    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign sdata_s     = sdata_sync[SYNC_STAGES-1];
    assign cs_rise_s   = cs_s & ~cs_prev;
    assign sclk_rise_s = sclk_s & ~sclk_prev;
    // The word completes on the 16th sclk edge; it is written on that same clk edge.
    assign wr_en_s     = (state == SHIFT) && cs_s && sclk_rise_s && (bit_cnt == 4'd15);
    assign wr_word_s   = {shift, sdata_s};

    // Input synchronizers and edge-detect history.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync    <= '0;
            sclk_sync  <= '0;
            sdata_sync <= '0;
            cs_prev    <= 1'b0;
            sclk_prev  <= 1'b0;
        end else begin
            cs_sync    <= {cs_sync[SYNC_STAGES-2:0], cs_in};
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata_in};
            cs_prev    <= cs_s;
            sclk_prev  <= sclk_s;
        end
    end

    // Receive FSM, bank swap and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            shift             <= '0;
            bit_cnt           <= 4'd0;
            word_ptr          <= 4'd0;
            bank_sel          <= 1'b0;
            frame_pending_out <= 1'b0;
            overrun_out       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt  <= 4'd0;
                    word_ptr <= 4'd0;
                    if (cs_rise_s) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!cs_s) begin
                        state    <= IDLE;
                        bit_cnt  <= 4'd0;
                        word_ptr <= 4'd0;
                    end else if (sclk_rise_s) begin
                        shift   <= {shift[WIDTH-3:0], sdata_s};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            word_ptr <= word_ptr + 4'd1;
                            if (word_ptr == 4'd15) begin
                                state <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    if (!cs_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Pending only becomes visible after the final write, so a same-cycle sync cannot swap.
            if (frame_sync_in && frame_pending_out) begin
                bank_sel          <= ~bank_sel;
                frame_pending_out <= 1'b0;
            end
            if (wr_en_s && (word_ptr == 4'd15)) begin
                frame_pending_out <= 1'b1;
            end
            if (wr_en_s && frame_pending_out) begin
                overrun_out <= 1'b1;
            end
        end
    end

    // Back bank storage; the front bank is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int w = 0; w < DEPTH; w++) begin
                    mem[b][w] <= '0;
                end
            end
        end else if (wr_en_s) begin
            mem[~bank_sel][word_ptr] <= wr_word_s;
        end
    end

    // Zero-latency column read from the front bank.
    always_comb begin
        rd_data = mem[bank_sel][rd_addr];
    end

    assign bank_out = bank_sel;

endmodule

// File: tb/tb_frame_loader.sv
// Directed self-checking bench for frame_loader: serial loads, aborts, swap timing,
// overrun and reset mid-load.
module tb_frame_loader;

    logic        clk;
    logic        reset;
    logic        cs_in;
    logic        sclk_in;
    logic        sdata_in;
    logic        frame_sync_in;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        frame_pending_out;
    logic        overrun_out;
    logic        bank_out;

    int n_cmp = 0;
    int n_err = 0;

    frame_loader #(.SYNC_STAGES(2), .WIDTH(16), .DEPTH(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .cs_in             (cs_in),
        .sclk_in           (sclk_in),
        .sdata_in          (sdata_in),
        .frame_sync_in     (frame_sync_in),
        .rd_addr           (rd_addr),
        .rd_data           (rd_data),
        .frame_pending_out (frame_pending_out),
        .overrun_out       (overrun_out),
        .bank_out          (bank_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All stimulus tasks are entered and left at a negedge of clk.
    task automatic send_bit(input logic b, input logic pulse_on_rise);
        sdata_in = b;
        sclk_in  = 1'b0;
        repeat (4) @(negedge clk);
        sclk_in = 1'b1;
        if (pulse_on_rise) begin
            repeat (2) @(negedge clk);
            frame_sync_in = 1'b1;
            @(negedge clk);
            frame_sync_in = 1'b0;
            @(negedge clk);
        end else begin
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i], 1'b0);
    endtask

    task automatic cs_begin();
        sclk_in = 1'b0;
        cs_in   = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_end();
        sclk_in = 1'b0;
        repeat (4) @(negedge clk);
        cs_in = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_frame_const(input logic [15:0] w, input logic pulse_last);
        cs_begin();
        for (int n = 0; n < 15; n++) send_word(w);
        for (int i = 15; i >= 1; i--) send_bit(w[i], 1'b0);
        send_bit(w[0], pulse_last);
    endtask

    task automatic pulse_sync();
        frame_sync_in = 1'b1;
        @(negedge clk);
        frame_sync_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            n_cmp++;
            if (rd_data !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_rd[%0d]: got %h expected 0000", a, rd_data);
            end
        end
        n_cmp++;
        if ({frame_pending_out, overrun_out, bank_out} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 000", {frame_pending_out, overrun_out, bank_out});
        end
    endtask

    task automatic test_full_frame();
        cs_begin();
        for (int n = 0; n < 16; n++) send_word(16'(16'h0101 * n));
        cs_end();
        rd_addr = 4'd3;
        #1;
        n_cmp++;
        if (frame_pending_out !== 1'b1) begin
            n_err++;
            $display("FAIL ff_pending: got %b expected 1", frame_pending_out);
        end
        n_cmp++;
        if (rd_data !== 16'h0000) begin
            n_err++;
            $display("FAIL ff_front_before_swap: got %h expected 0000", rd_data);
        end
        pulse_sync();
        n_cmp++;
        if ({bank_out, frame_pending_out} !== 2'b10) begin
            n_err++;
            $display("FAIL ff_swap_flags: got %b expected 10", {bank_out, frame_pending_out});
        end
        rd_addr = 4'd3;
        #1;
        n_cmp++;
        if (rd_data !== 16'h0303) begin
            n_err++;
            $display("FAIL ff_rd3: got %h expected 0303", rd_data);
        end
        rd_addr = 4'd15;
        #1;
        n_cmp++;
        if (rd_data !== 16'h0F0F) begin
            n_err++;
            $display("FAIL ff_rd15: got %h expected 0f0f", rd_data);
        end
        rd_addr = 4'd0;
        #1;
        n_cmp++;
        if (rd_data !== 16'h0000) begin
            n_err++;
            $display("FAIL ff_rd0: got %h expected 0000", rd_data);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        cs_begin();
        send_word(16'hFFFF);
        send_word(16'hFFFF);
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
        cs_end();
        pulse_sync();
        n_cmp++;
        if ({bank_out, frame_pending_out} !== 2'b10) begin
            n_err++;
            $display("FAIL abort_no_swap: got %b expected 10", {bank_out, frame_pending_out});
        end
        send_frame_const(16'hA5A5, 1'b0);
        cs_end();
        pulse_sync();
        n_cmp++;
        if ({bank_out, frame_pending_out} !== 2'b00) begin
            n_err++;
            $display("FAIL abort_reload_swap: got %b expected 00", {bank_out, frame_pending_out});
        end
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            n_cmp++;
            if (rd_data !== 16'hA5A5) begin
                n_err++;
                $display("FAIL abort_rd[%0d]: got %h expected a5a5", a, rd_data);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_sync_collision();
        send_frame_const(16'h5A5A, 1'b1);
        n_cmp++;
        if ({bank_out, frame_pending_out} !== 2'b01) begin
            n_err++;
            $display("FAIL coll_no_swap: got %b expected 01", {bank_out, frame_pending_out});
        end
        cs_end();
        pulse_sync();
        n_cmp++;
        if ({bank_out, frame_pending_out} !== 2'b10) begin
            n_err++;
            $display("FAIL coll_later_swap: got %b expected 10", {bank_out, frame_pending_out});
        end
        rd_addr = 4'd7;
        #1;
        n_cmp++;
        if (rd_data !== 16'h5A5A) begin
            n_err++;
            $display("FAIL coll_rd7: got %h expected 5a5a", rd_data);
        end
        @(negedge clk);
    endtask

    task automatic test_overrun();
        send_frame_const(16'hC3C3, 1'b0);
        cs_end();
        n_cmp++;
        if ({frame_pending_out, overrun_out} !== 2'b10) begin
            n_err++;
            $display("FAIL ovr_before: got %b expected 10", {frame_pending_out, overrun_out});
        end
        cs_begin();
        send_word(16'h00FF);
        cs_end();
        n_cmp++;
        if ({frame_pending_out, overrun_out} !== 2'b11) begin
            n_err++;
            $display("FAIL ovr_set: got %b expected 11", {frame_pending_out, overrun_out});
        end
        pulse_sync();
        n_cmp++;
        if ({bank_out, frame_pending_out, overrun_out} !== 3'b001) begin
            n_err++;
            $display("FAIL ovr_after_swap: got %b expected 001", {bank_out, frame_pending_out, overrun_out});
        end
        rd_addr = 4'd0;
        #1;
        n_cmp++;
        if (rd_data !== 16'h00FF) begin
            n_err++;
            $display("FAIL ovr_rd0: got %h expected 00ff", rd_data);
        end
        rd_addr = 4'd1;
        #1;
        n_cmp++;
        if (rd_data !== 16'hC3C3) begin
            n_err++;
            $display("FAIL ovr_rd1: got %h expected c3c3", rd_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midload();
        cs_begin();
        for (int n = 0; n < 7; n++) send_word(16'hBEEF);
        reset   = 1'b1;
        cs_in   = 1'b0;
        sclk_in = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bank_out, frame_pending_out, overrun_out} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_mid_flags: got %b expected 000", {bank_out, frame_pending_out, overrun_out});
        end
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            n_cmp++;
            if (rd_data !== 16'h0000) begin
                n_err++;
                $display("FAIL rst_mid_rd[%0d]: got %h expected 0000", a, rd_data);
            end
        end
        @(negedge clk);
        send_frame_const(16'h1234, 1'b0);
        cs_end();
        pulse_sync();
        n_cmp++;
        if ({bank_out, frame_pending_out} !== 2'b10) begin
            n_err++;
            $display("FAIL rst_reload_swap: got %b expected 10", {bank_out, frame_pending_out});
        end
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            n_cmp++;
            if (rd_data !== 16'h1234) begin
                n_err++;
                $display("FAIL rst_reload_rd[%0d]: got %h expected 1234", a, rd_data);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset         = 1'b1;
        cs_in         = 1'b0;
        sclk_in       = 1'b0;
        sdata_in      = 1'b0;
        frame_sync_in = 1'b0;
        rd_addr       = 4'd0;
        @(negedge clk);
        test_reset();
        test_full_frame();
        test_abort();
        test_sync_collision();
        test_overrun();
        test_reset_midload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/frame_loader.md
Name: frame_loader

Overview:
Double-buffered 16x16 one-bit frame store sitting directly upstream of the LED panel driver. Accepts pixel data over a slow 3-wire serial interface (cs/sclk/sdata) from off-chip pins into a back bank. Swaps the back bank to the front only at a frame boundary signalled by the panel driver, so the driver never displays a torn frame. Exposes a zero-latency column read port that the panel driver indexes as frame_buffer[column][row].

Parameters:
SYNC_STAGES, 2, flops in each input synchronizer for sclk_in, sdata_in and cs_in (minimum 2).
WIDTH, 16, bits per word (one word is one column; bit index is the row); fixed at 16.
DEPTH, 16, words per bank; fixed at 16.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
cs_in  input  1  async serial frame select, active-high
sclk_in  input  1  async serial bit clock; data is sampled on its rising edge
sdata_in  input  1  async serial data, MSB first
frame_sync_in  input  1  one-cycle pulse from the panel driver at frame start
rd_addr  input  4  column index into the front bank
rd_data  output  16  front bank word at rd_addr, combinational
frame_pending_out  output  1  a complete frame is waiting in the back bank
overrun_out  output  1  sticky flag: a pending frame was overwritten before the swap
bank_out  output  1  current front bank select (debug)

Behaviour:
- Reset (synchronous, active-high; clock clk): both banks cleared to 0; bank_sel=0; shift register, bit_cnt[3:0] and word_ptr[3:0] cleared to 0; frame_pending_out=0; overrun_out=0; synchronizers cleared to 0. After reset, rd_data=0 for every rd_addr.
- Synchronization: each async input passes through SYNC_STAGES flops. Rising edge of sclk = synced value is 1 and the previous synced value was 0. sclk high and low phases must each last at least SYNC_STAGES+1 clk cycles.
- Receive FSM states:
  - IDLE: entered when synced cs=0. bit_cnt and word_ptr are held at 0.
  - SHIFT: entered on a synced cs 0->1 edge. On each sclk rising edge: shift <= {shift[14:0], sdata}; bit_cnt <= bit_cnt+1.
    - On the edge where bit_cnt==15, the word {shift[14:0], sdata} is written to back[word_ptr] on that same clk edge. bit_cnt then wraps to 0 and word_ptr increments.
    - When word_ptr==15 and its write completes, go to DONE and set frame_pending_out=1 on the next clk cycle.
  - DONE: sclk edges are ignored until cs falls; a cs fall returns the FSM to IDLE.
- Word and bit order: the first word goes to column 0; the first bit received lands in bit 15 of the word.
- cs fall mid-word or mid-frame: the partial word is discarded. Words already written stay in the back bank. frame_pending_out is not set. The next cs rise restarts at word 0, bit 0.
- Swap: on frame_sync_in=1 with frame_pending_out=1, the next cycle has bank_sel toggled and frame_pending_out=0. frame_sync_in with frame_pending_out=0 does nothing.
- Simultaneous events:
  - frame_sync_in arriving in the same cycle as the final word write: no swap, because pending is not yet visible. The swap happens at the next frame_sync_in.
  - Load starting while frame_pending_out=1: the first word write into the back bank sets overrun_out (sticky until reset). frame_pending_out stays 1.
  - frame_sync_in during an active load with pending=0: no effect on the load.
- Read port: rd_data = front[rd_addr], purely combinational, 0 cycles latency. The front bank contents change only at a swap or at reset.
- Reset mid-load: everything returns to reset values immediately. The partial frame is lost and both banks read 0.

Test Plan:
- Reset, then read rd_addr 0..15 -> rd_data=16'h0000 for all; frame_pending_out=0; bank_out=0.
- Load 256 bits in which word n=16'h0101*n (n=0..15), then drop cs -> frame_pending_out=1 and rd_data is still 0. Pulse frame_sync_in -> next cycle bank_out=1, frame_pending_out=0, rd_addr=3 gives 16'h0303, rd_addr=15 gives 16'h0F0F.
- Send 40 bits (2 words of 16'hFFFF plus 8 bits), then drop cs and pulse frame_sync_in -> no swap, frame_pending_out=0. Reload a full frame of 16'hA5A5 and swap -> every rd_data=16'hA5A5.
- Pulse frame_sync_in in the exact cycle of the 16th word write -> bank_out unchanged. Pulse again later -> bank_out toggles.
- With frame_pending_out=1, start a new load of 1 word -> overrun_out=1 and frame_pending_out stays 1. After a swap, overrun_out stays 1 until reset.
- Assert reset after 7 words of a load -> all outputs at reset values. A subsequent full load of 16'h1234 followed by a swap reads 16'h1234 on every address.
